// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: one request at a time, alignment check,
// req/gnt/rvalid bus handshake and load-data extraction with extension.
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_sel,
    input  logic [3:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [63:0] bus_rdata,
    input  logic        bus_err,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        resp_misalign
);

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic                accept, misalign;
    logic                cap_we, cap_unsigned;
    logic [DATA_W-1:0]   cap_addr, cap_wdata;
    logic [7:0]          cap_sel;
    logic [3:0]          cap_size;
    logic [DATA_W-1:0]   res_data;
    logic                res_err, res_misalign;

    // Size is one-hot {dword, word, half, byte}; wider sizes take priority.
    function automatic logic [DATA_W-1:0] format_load(input logic [DATA_W-1:0] rdata,
                                                      input logic [2:0]        off,
                                                      input logic [3:0]        size,
                                                      input logic              uns);
        logic [DATA_W-1:0] sh;
        logic              sgn;
        sh = rdata >> {off, 3'b000};
        if (size[3]) begin
            format_load = sh;
        end else if (size[2]) begin
            sgn = sh[31] & ~uns;
            format_load = {{32{sgn}}, sh[31:0]};
        end else if (size[1]) begin
            sgn = sh[15] & ~uns;
            format_load = {{48{sgn}}, sh[15:0]};
        end else begin
            sgn = sh[7] & ~uns;
            format_load = {{56{sgn}}, sh[7:0]};
        end
    endfunction

    always_comb begin
        misalign = (req_size == 4'd0) || (req_sel == 8'd0)
                || (req_size[1] && req_addr[0])
                || (req_size[2] && (req_addr[1:0] != 2'd0))
                || (req_size[3] && (req_addr[2:0] != 3'd0));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = misalign ? RESP : REQ;
            REQ:     if (bus_gnt) state_nxt = WAIT;
            WAIT:    if (bus_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is forced low while reset is high, whatever the state.
    always_comb begin
        req_ready     = 1'b0;
        accept        = 1'b0;
        stall         = 1'b0;
        bus_req       = 1'b0;
        bus_we        = 1'b0;
        bus_addr      = '0;
        bus_wdata     = '0;
        bus_wstrb     = '0;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_err      = 1'b0;
        resp_misalign = 1'b0;
        if (!rst) begin
            req_ready = (state == IDLE);
            accept    = req_valid && (state == IDLE);
            stall     = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
            if (state == REQ) begin
                bus_req   = 1'b1;
                bus_we    = cap_we;
                bus_addr  = {cap_addr[DATA_W-1:3], 3'b000};
                bus_wdata = cap_wdata;
                bus_wstrb = cap_we ? cap_sel : 8'd0;
            end
            if (state == RESP) begin
                resp_valid    = 1'b1;
                resp_data     = res_data;
                resp_err      = res_err;
                resp_misalign = res_misalign;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Request capture at acceptance and result latch on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we       <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_sel      <= '0;
            cap_size     <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
            res_misalign <= 1'b0;
        end else begin
            if (accept) begin
                cap_we       <= req_we;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_sel      <= req_sel;
                cap_size     <= req_size;
                res_data     <= '0;
                res_err      <= misalign;
                res_misalign <= misalign;
            end
            if ((state == WAIT) && bus_rvalid) begin
                res_err      <= bus_err;
                res_misalign <= 1'b0;
                res_data     <= (bus_err || cap_we) ? '0
                              : format_load(bus_rdata, cap_addr[2:0], cap_size, cap_unsigned);
            end
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Sequencing controller between the combinational `lsu` address/strobe stage and the external data-memory bus. It accepts one load/store request at a time and checks alignment. It drives a req/gnt/rvalid bus transaction, stalls the pipeline until the transaction completes, and returns load data shifted and sign- or zero-extended to 64 bits. It sits in the MEM stage, directly downstream of `lsu`.

## Interface
Parameters: none; all widths fixed at 64-bit data/address, 8 byte lanes.

- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  LSU access valid (`data_sram_en` of `lsu`)
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  lane-replicated store data
- `req_sel`  in  8  byte-lane select (`data_ram_sel`)
- `req_size`  in  4  one-hot {dword, word, half, byte}
- `req_unsigned`  in  1  zero-extend load when 1
- `req_ready`  out  1  controller can accept a request this cycle
- `stall`  out  1  freeze MEM and earlier stages
- `bus_req`  out  1  bus request
- `bus_we`  out  1  bus write
- `bus_addr`  out  64  `{addr[63:3],3'b000}`
- `bus_wdata`  out  64  store data
- `bus_wstrb`  out  8  write strobes; `req_sel` for stores, 0 for loads
- `bus_gnt`  in  1  request accepted by bus
- `bus_rvalid`  in  1  read data valid or write acknowledged
- `bus_rdata`  in  64  read data
- `bus_err`  in  1  bus error; qualified by `bus_rvalid`
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_data`  out  64  formatted load data; 0 for stores and errors
- `resp_err`  out  1  access faulted (misaligned or bus error)
- `resp_misalign`  out  1  fault cause is misalignment

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- `req_ready = (state==IDLE) & ~rst`. A request is accepted when `req_valid & req_ready`. All `req_*` fields are captured into registers at acceptance. `req_*` is ignored in every other state.
- Misalignment is checked at acceptance:
  - half: `addr[0]!=0`
  - word: `addr[1:0]!=0`
  - dword: `addr[2:0]!=0`
  - `req_size==0` or `req_sel==0` also counts as misaligned.
- IDLE transitions on acceptance:
  - Misaligned: go to RESP with err=1, misalign=1. No bus activity.
  - Otherwise: go to REQ.
- REQ: `bus_req=1`; bus_we, addr, wdata and wstrb are driven from the captured registers and held stable. If `bus_gnt` is 1, go to WAIT next edge; otherwise stay in REQ.
- WAIT: `bus_req=0`. On `bus_rvalid`, latch the result and go to RESP. Any `bus_rvalid` outside WAIT is ignored.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- Load formatting uses `off = addr[2:0]` and `sh = bus_rdata >> (8*off)`:
  - byte: `sh[7:0]`
  - half: `sh[15:0]`
  - word: `sh[31:0]`
  - dword: `bus_rdata`
- Extension: sign-extend from the MSB of the field unless `req_unsigned`; then zero-extend.
- Store response: `resp_data=0`.
- `bus_err=1` with `bus_rvalid` gives `resp_err=1`, `resp_misalign=0`, `resp_data=0`.
- `stall = (state==IDLE & req_valid & ~rst) | state==REQ | state==WAIT`. `stall` is 0 in RESP, so the pipeline advances on the completion cycle. The upstream instruction holds `req_valid` and fields until then.
- Reset mid-operation: next edge returns to IDLE and clears the captured registers. `bus_req` drops. A late `bus_rvalid` is ignored.

## Timing
- Reset values: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `resp_valid`, `resp_data`, `resp_err`, `resp_misalign`, `stall` and `req_ready` are all 0 while `rst` is high.
- Bus outputs are decoded from registered state. No combinational path from `bus_*` inputs to `bus_*` outputs.
- Aligned access: accept at T, `bus_req` at T+1, earliest gnt at T+1, earliest rvalid at T+2, `resp_valid` at T+3. Minimum latency is 3 cycles; each stall cycle of gnt or rvalid adds 1.
- Misaligned access: accept at T, `resp_valid` at T+1 with 0 bus cycles.
- Back-to-back: RESP → IDLE takes one cycle, so the next acceptance is no earlier than RESP+1.
- `bus_gnt` and `bus_rvalid` never coincide for the same transaction. The bus guarantees rvalid ≥1 cycle after gnt.

## Test plan
- Signed load byte: addr=0x1003, size=byte, unsigned=0, rdata=0x0000_0000_8000_0000 (byte 3 = 0x80), gnt at T+1, rvalid at T+2 → `resp_valid` at T+3, `resp_data=0xFFFF_FFFF_FFFF_FF80`, `stall` high T..T+2 only.
- Unsigned load half at addr=0x2006 with rdata=0xBEEF_0000_0000_0000 → `resp_data=0x0000_0000_0000_BEEF`. Word at addr=0x2004, signed, rdata upper=0x8000_0001 → `0xFFFF_FFFF_8000_0001`.
- Store dword: addr=0x3000, wdata=0x0123_4567_89AB_CDEF, sel=0xFF, gnt delayed 3 cycles → `bus_req` held 4 cycles with stable addr/wdata, `bus_wstrb=0xFF`, `resp_data=0`, `resp_err=0`.
- Misaligned word at addr=0x4002 → no `bus_req`, `resp_valid` at T+1 with `resp_err=1`, `resp_misalign=1`.
- Bus error: load, rvalid with `bus_err=1` → `resp_err=1`, `resp_misalign=0`, `resp_data=0`.
- Reset asserted in WAIT, then rvalid pulsed after reset release → state IDLE, all outputs 0, no `resp_valid`. The next request completes normally.
